// File: rtl/fft_frame_packer_if.sv
// Stream-in / frame-out bundle of the FFT frame packer.
// The slave modport is the packer; the master modport is the source and FFT side.
interface fft_frame_packer_if #(
   parameter int unsigned N_POINTS = 32,
   parameter int unsigned DATA_W   = 8
);
   localparam int unsigned LEN_W = $clog2(N_POINTS + 1);

   logic                         s_valid;
   logic                         s_ready;
   logic [DATA_W-1:0]            s_data;
   logic                         s_last;
   logic                         m_valid;
   logic                         m_ready;
   logic [N_POINTS*DATA_W-1:0]   m_data;
   logic [LEN_W-1:0]             m_len;
   logic [7:0]                   m_seq;

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_len, m_seq
   );

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data, m_len, m_seq
   );
endinterface

// File: rtl/fft_frame_packer.sv
// Serial-to-parallel packer: fills two ping-pong banks with samples and presents
// each closed frame (zero-padded after an early s_last) as one parallel word.
module fft_frame_packer #(
   parameter int unsigned N_POINTS = 32,
   parameter int unsigned DATA_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   fft_frame_packer_if.slave io_bus
);
   localparam int unsigned LEN_W = $clog2(N_POINTS + 1);
   localparam int unsigned IDX_W = $clog2(N_POINTS);

   logic [DATA_W-1:0]          r_mem [2][N_POINTS];
   logic [LEN_W-1:0]           r_len [2];
   logic                       r_wr_bank;
   logic                       r_rd_bank;
   logic [1:0]                 r_full_cnt;
   logic [IDX_W-1:0]           r_wr_idx;
   logic [7:0]                 r_seq;

   logic                       w_s_ready;
   logic                       w_m_valid;
   logic                       w_accept;
   logic                       w_close;
   logic                       w_consume;
   logic [LEN_W-1:0]           w_rd_len;
   logic [N_POINTS*DATA_W-1:0] w_m_data;

   // Banks fill and drain strictly alternately, so one pointer each suffices.
   assign w_s_ready = !rst && (r_full_cnt != 2'd2);
   assign w_m_valid = !rst && (r_full_cnt != 2'd0);
   assign w_accept  = io_bus.s_valid && w_s_ready;
   assign w_close   = w_accept && ((r_wr_idx == IDX_W'(N_POINTS - 1)) || io_bus.s_last);
   assign w_consume = w_m_valid && io_bus.m_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_full_cnt <= '0;
         r_wr_idx   <= '0;
         r_seq      <= '0;
      end else begin
         if (w_accept) begin
            r_wr_idx <= w_close ? '0 : r_wr_idx + IDX_W'(1);
         end
         if (w_close) begin
            r_wr_bank <= ~r_wr_bank;
         end
         if (w_consume) begin
            r_rd_bank <= ~r_rd_bank;
            r_seq     <= r_seq + 8'd1;
         end
         case ({w_close, w_consume})
            2'b10:   r_full_cnt <= r_full_cnt + 2'd1;
            2'b01:   r_full_cnt <= r_full_cnt - 2'd1;
            default: r_full_cnt <= r_full_cnt;
         endcase
      end
   end

   // Sample storage needs no reset: nothing is presented until a bank closes.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wr_bank][r_wr_idx] <= io_bus.s_data;
      end
      if (w_close) begin
         r_len[r_wr_bank] <= LEN_W'(r_wr_idx) + LEN_W'(1);
      end
   end

   // Lanes past the stored length read zero, so stale samples never leak out.
   always_comb begin
      w_m_data = '0;
      w_rd_len = r_len[r_rd_bank];
      for (int unsigned k = 0; k < N_POINTS; k++) begin
         if (w_m_valid && (k < 32'(w_rd_len))) begin
            w_m_data[k*DATA_W +: DATA_W] = r_mem[r_rd_bank][IDX_W'(k)];
         end
      end
   end

   assign io_bus.s_ready = w_s_ready;
   assign io_bus.m_valid = w_m_valid;
   assign io_bus.m_data  = w_m_data;
   assign io_bus.m_len   = w_m_valid ? w_rd_len : '0;
   assign io_bus.m_seq   = rst ? '0 : r_seq;
endmodule

// File: tb/tb_fft_frame_packer.sv
// Directed bench for fft_frame_packer: vector table plus hand-written
// back-pressure, close/consume collision, reset and sequence-wrap sequences.
module tb_fft_frame_packer;
   localparam int unsigned N = 32;
   localparam int unsigned W = 8;

   typedef struct {
      logic [N*W-1:0] data;
      int unsigned    len;
      logic [7:0]     seq;
   } frame_t;

   typedef struct {
      int unsigned n;
      logic        last;
      logic [7:0]  base;
      int unsigned exp_len;
      logic [7:0]  exp_end;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fft_frame_packer_if #(.N_POINTS(N), .DATA_W(W)) u_if ();
   fft_frame_packer #(.N_POINTS(N), .DATA_W(W)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (u_if)
   );

   int unsigned    n_cmp = 0;
   int unsigned    n_bad = 0;
   int unsigned    n_seen = 0;
   logic [7:0]     last_seq = 8'hAA;
   frame_t         exp_q[$];
   logic [N*W-1:0] mdl_data;
   int unsigned    mdl_idx;
   logic [7:0]     mdl_seq;

   task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mdl_data = '0;
      mdl_idx  = 0;
      mdl_seq  = 8'd0;
      exp_q.delete();
   endtask

   task automatic model_accept(input logic [W-1:0] d, input logic last);
      mdl_data[mdl_idx*W +: W] = d;
      mdl_idx++;
      if (mdl_idx == N || last) begin
         exp_q.push_back('{data: mdl_data, len: mdl_idx, seq: mdl_seq});
         mdl_seq  = mdl_seq + 8'd1;
         mdl_data = '0;
         mdl_idx  = 0;
      end
   endtask

   // Returns 1 time unit after the accepting edge with s_valid dropped.
   task automatic send(input logic [W-1:0] d, input logic last);
      int unsigned t = 0;
      u_if.s_valid = 1'b1;
      u_if.s_data  = d;
      u_if.s_last  = last;
      while (1) begin
         @(negedge clk);
         if (u_if.s_ready) break;
         t++;
         if (t > 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: s_ready low for %0d cycles, required high", t);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $fatal(1, "stalled source");
         end
      end
      @(posedge clk);
      model_accept(d, last);
      #1;
      u_if.s_valid = 1'b0;
      u_if.s_last  = 1'b0;
   endtask

   task automatic idle(input int unsigned cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : mon
      frame_t f;
      if (!rst && u_if.m_valid && u_if.m_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got seq %0d, required no frame", u_if.m_seq);
         end else begin
            f = exp_q.pop_front();
            chk("frame_data", u_if.m_data, f.data);
            chk("frame_len", u_if.m_len, f.len);
            chk("frame_seq", u_if.m_seq, f.seq);
            last_seq = u_if.m_seq;
            n_seen++;
         end
      end
   end

   initial begin
      vec_t           tbl[6];
      logic [N*W-1:0] md;
      logic [N*W-1:0] exp0;
      logic [7:0]     bseq;

      tbl[0] = '{5,  1'b1, 8'h10, 5,  8'h14};
      tbl[1] = '{1,  1'b1, 8'hA0, 1,  8'hA0};
      tbl[2] = '{31, 1'b1, 8'h00, 31, 8'h1E};
      tbl[3] = '{32, 1'b0, 8'hE0, 32, 8'hFF};
      tbl[4] = '{32, 1'b1, 8'h40, 32, 8'h5F};
      tbl[5] = '{2,  1'b1, 8'h7F, 2,  8'h80};

      rst = 1'b1;
      u_if.s_valid = 1'b0;
      u_if.s_data  = '0;
      u_if.s_last  = 1'b0;
      u_if.m_ready = 1'b0;
      model_reset();

      // Reset values, during and immediately after reset
      @(posedge clk); #1;
      chk("rst_s_ready", u_if.s_ready, 0);
      chk("rst_m_valid", u_if.m_valid, 0);
      chk("rst_m_data", u_if.m_data, 0);
      chk("rst_m_len", u_if.m_len, 0);
      chk("rst_m_seq", u_if.m_seq, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst_s_ready", u_if.s_ready, 1);
      chk("post_rst_m_valid", u_if.m_valid, 0);
      chk("post_rst_m_data", u_if.m_data, 0);
      chk("post_rst_m_len", u_if.m_len, 0);
      chk("post_rst_m_seq", u_if.m_seq, 0);

      // Full 32-sample frame 0x01..0x20
      u_if.m_ready = 1'b1;
      for (int i = 1; i <= 32; i++) send(8'(i), i == 32);
      md = u_if.m_data;
      chk("full_m_valid", u_if.m_valid, 1);
      chk("full_lane0", md[0 +: 8], 8'h01);
      chk("full_lane31", md[31*8 +: 8], 8'h20);
      chk("full_m_len", u_if.m_len, 32);
      chk("full_m_seq", u_if.m_seq, 0);
      idle(1);
      chk("full_valid_one_cycle", u_if.m_valid, 0);

      // Vector table of varying lengths
      for (int v = 0; v < 6; v++) begin
         for (int unsigned j = 0; j < tbl[v].n; j++)
            send(8'(tbl[v].base + 8'(j)), (j == tbl[v].n - 1) && tbl[v].last);
         md = u_if.m_data;
         chk("tbl_m_valid", u_if.m_valid, 1);
         chk("tbl_m_len", u_if.m_len, tbl[v].exp_len);
         chk("tbl_lane0", md[0 +: 8], tbl[v].base);
         chk("tbl_lane_end", md[(tbl[v].exp_len-1)*8 +: 8], tbl[v].exp_end);
         if (tbl[v].exp_len < N) chk("tbl_lane_pad", md[tbl[v].exp_len*8 +: 8], 0);
      end

      // Signed-extreme short frame, whole word including padding
      send(8'h7F, 1'b0); send(8'h80, 1'b0); send(8'h00, 1'b0);
      send(8'hFF, 1'b0); send(8'h40, 1'b1);
      exp0 = '0;
      exp0[39:0] = 40'h40FF00807F;
      chk("short_m_data", u_if.m_data, exp0);
      chk("short_m_len", u_if.m_len, 5);
      idle(1);
      u_if.m_ready = 1'b0;

      // Back-pressure: 96 samples with the FFT stalled
      bseq = mdl_seq;
      exp0 = '0;
      for (int unsigned k = 0; k < N; k++) exp0[k*8 +: 8] = 8'(k + 1);
      for (int i = 0; i < 64; i++) send(8'(i + 1), 1'b0);
      chk("bp_s_ready_drop", u_if.s_ready, 0);
      chk("bp_m_valid", u_if.m_valid, 1);
      chk("bp_m_seq", u_if.m_seq, bseq);
      chk("bp_m_data", u_if.m_data, exp0);
      idle(3);
      chk("bp_hold_data", u_if.m_data, exp0);
      chk("bp_hold_s_ready", u_if.s_ready, 0);
      u_if.m_ready = 1'b1;
      idle(1);
      u_if.m_ready = 1'b0;
      chk("bp_seq_adv", u_if.m_seq, 8'(bseq + 8'd1));
      chk("bp_s_ready_back", u_if.s_ready, 1);
      for (int i = 64; i < 96; i++) send(8'(i + 1), 1'b0);
      chk("bp_second_full", u_if.s_ready, 0);

      // Close and consume on the same edge
      u_if.m_ready = 1'b1;
      idle(1);
      u_if.m_ready = 1'b0;
      chk("cc_s_ready_pre", u_if.s_ready, 1);
      chk("cc_seq_pre", u_if.m_seq, 8'(bseq + 8'd2));
      for (int j = 0; j < 31; j++) send(8'(8'hA0 + 8'(j)), 1'b0);
      u_if.m_ready = 1'b1;
      send(8'hBF, 1'b0);
      chk("cc_s_ready_kept", u_if.s_ready, 1);
      chk("cc_m_valid", u_if.m_valid, 1);
      chk("cc_seq_next", u_if.m_seq, 8'(bseq + 8'd3));
      idle(1);
      chk("cc_drained", u_if.m_valid, 0);

      // Reset mid-frame with one full frame pending
      u_if.m_ready = 1'b0;
      for (int j = 0; j < 49; j++) send(8'(8'h50 + 8'(j)), 1'b0);
      rst = 1'b1;
      #1;
      chk("mrst_valid_in_rst", u_if.m_valid, 0);
      chk("mrst_ready_in_rst", u_if.s_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      #1;
      chk("mrst_m_valid", u_if.m_valid, 0);
      chk("mrst_m_seq", u_if.m_seq, 0);
      chk("mrst_s_ready", u_if.s_ready, 1);
      u_if.m_ready = 1'b1;
      for (int j = 0; j < 32; j++) send(8'(8'hC0 + 8'(j)), 1'b0);
      chk("mrst_new_valid", u_if.m_valid, 1);
      chk("mrst_new_seq", u_if.m_seq, 0);
      idle(1);

      // 257 frames: sequence number wraps back to 0
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      n_seen = 0;
      for (int f = 0; f < 257; f++)
         for (int k = 0; k < 32; k++)
            send(8'(f + k), (k == 31) && (f % 2 == 1));

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("wrap_frames_seen", n_seen, 257);
      chk("wrap_last_seq", last_seq, 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
